// File: rtl/fft_pkg.sv
// Shared definitions for the in-place radix-2 FFT RAM scheduler.
// Holds the scheduler FSM state encoding and the default geometry constants.
// No ports; imported by fft_addr_gen and fft_ram_sched.
package fft_pkg;

   localparam int DEF_CMD_WIDTH = 4;   // RAM address width, N = 2^CMD_WIDTH points
   localparam int DEF_BF_LAT    = 2;   // external butterfly latency in cycles

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_BF   = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address / twiddle generator for a DIT FFT over bit-reversed RAM contents.
// Latency: purely combinational from (s, k). No flow control.
// Ports: s = stage, k = pair index; addra/addrb = top/bottom addresses, tw_idx = twiddle ROM index.
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int CMD_WIDTH = DEF_CMD_WIDTH,
   localparam int SW       = $clog2(CMD_WIDTH)
) (
   input  logic [SW-1:0]        s,
   input  logic [CMD_WIDTH-2:0] k,
   output logic [CMD_WIDTH-1:0] addra,
   output logic [CMD_WIDTH-1:0] addrb,
   output logic [CMD_WIDTH-2:0] tw_idx
);

   logic [CMD_WIDTH-1:0] span;
   logic [CMD_WIDTH-1:0] mask;
   logic [CMD_WIDTH-1:0] kk;
   logic [SW-1:0]        tw_shift;

   always_comb begin
      span     = CMD_WIDTH'(1) << s;
      mask     = span - CMD_WIDTH'(1);
      kk       = {1'b0, k};
      // Insert a zero at bit position s: group bits move up one place, offset bits stay.
      // Shifting by 1 then by s avoids s+1 overflowing the SW-bit stage width.
      addra    = (((kk >> s) << 1) << s) | (kk & mask);
      // Bit s of addra is always 0, so this add never carries out.
      addrb    = addra + span;
      // s never exceeds CMD_WIDTH-1, so this subtraction cannot underflow.
      tw_shift = SW'(CMD_WIDTH - 1) - s;
      tw_idx   = (k & mask[CMD_WIDTH-2:0]) << tw_shift;
   end

endmodule

// File: rtl/fft_ram_sched.sv
// In-place radix-2 DIT FFT RAM scheduler: RD -> BF (BF_LAT cycles) -> WR per butterfly, all stages.
// Latency: CMD_WIDTH * N/2 * (BF_LAT+2) cycles from START acceptance to the DONE pulse; outputs registered.
// Backpressure: none; START is only sampled in IDLE. Optional ABORT input under FFT_RAM_SCHED_ABORT_EN.
// Ports: CLK/RST (async active-high), START in; BUSY, DONE, ENA/ENB, WEA/WEB, ADDRA/ADDRB,
//        TW_IDX, STAGE, BF_IN_VALID out. ABORT in only when FFT_RAM_SCHED_ABORT_EN is defined.
module fft_ram_sched
   import fft_pkg::*;
#(
   parameter int CMD_WIDTH = DEF_CMD_WIDTH,
   parameter int BF_LAT    = DEF_BF_LAT
) (
   input  logic                         CLK,
   input  logic                         RST,
`ifdef FFT_RAM_SCHED_ABORT_EN
   input  logic                         ABORT,
`endif
   input  logic                         START,
   output logic                         BUSY,
   output logic                         DONE,
   output logic                         ENA,
   output logic                         ENB,
   output logic                         WEA,
   output logic                         WEB,
   output logic [CMD_WIDTH-1:0]         ADDRA,
   output logic [CMD_WIDTH-1:0]         ADDRB,
   output logic [CMD_WIDTH-2:0]         TW_IDX,
   output logic [$clog2(CMD_WIDTH)-1:0] STAGE,
   output logic                         BF_IN_VALID
);

   localparam int SW    = $clog2(CMD_WIDTH);
   localparam int KW    = CMD_WIDTH - 1;
   localparam int CNT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

   localparam logic [KW-1:0]    K_LAST   = {KW{1'b1}};
   localparam logic [SW-1:0]    S_LAST   = SW'(CMD_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BF_LAT - 1);

   // control state
   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [SW-1:0]    s_q, s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // registered outputs
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 en_q, en_d;
   logic                 we_q, we_d;
   logic [CMD_WIDTH-1:0] addra_q, addra_d;
   logic [CMD_WIDTH-1:0] addrb_q, addrb_d;
   logic [KW-1:0]        tw_idx_q, tw_idx_d;
   logic [SW-1:0]        stage_q, stage_d;
   logic                 bf_in_valid_q, bf_in_valid_d;

   logic [CMD_WIDTH-1:0] gen_addra;
   logic [CMD_WIDTH-1:0] gen_addrb;
   logic [KW-1:0]        gen_tw_idx;
   logic                 in_run;

   // Fed from the next-state indices so the registered addresses line up with the
   // state they belong to, and stay constant across RD, BF and WR of one butterfly.
   fft_addr_gen #(
      .CMD_WIDTH (CMD_WIDTH)
   ) u_addr_gen (
      .s      (s_d),
      .k      (k_d),
      .addra  (gen_addra),
      .addrb  (gen_addrb),
      .tw_idx (gen_tw_idx)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      s_d     = s_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            state_d = ST_BF;
            cnt_d   = CNT_INIT;
         end
         ST_BF: begin
            if (cnt_q == '0) begin
               state_d = ST_WR;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_WR: begin
            if (k_q == K_LAST) begin
               k_d = '0;
               if (s_q == S_LAST) begin
                  s_d     = '0;
                  state_d = ST_DONE;
               end else begin
                  s_d     = s_q + SW'(1);
                  state_d = ST_RD;
               end
            end else begin
               k_d     = k_q + KW'(1);
               state_d = ST_RD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef FFT_RAM_SCHED_ABORT_EN
      // Abort only cuts an active run; IDLE and DONE are unaffected.
      if (ABORT && (state_q == ST_RD || state_q == ST_BF || state_q == ST_WR)) begin
         state_d = ST_IDLE;
         k_d     = '0;
         s_d     = '0;
         cnt_d   = '0;
      end
`endif

      in_run        = (state_d == ST_RD) || (state_d == ST_BF) || (state_d == ST_WR);
      busy_d        = in_run;
      done_d        = (state_d == ST_DONE);
      en_d          = (state_d == ST_RD) || (state_d == ST_WR);
      we_d          = (state_d == ST_WR);
      // RAM read data appears the cycle after RD, i.e. the first BF cycle.
      bf_in_valid_d = (state_q == ST_RD) && (state_d == ST_BF);
      addra_d       = in_run ? gen_addra  : '0;
      addrb_d       = in_run ? gen_addrb  : '0;
      tw_idx_d      = in_run ? gen_tw_idx : '0;
      stage_d       = in_run ? s_d        : '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= ST_IDLE;
         k_q           <= '0;
         s_q           <= '0;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         en_q          <= 1'b0;
         we_q          <= 1'b0;
         addra_q       <= '0;
         addrb_q       <= '0;
         tw_idx_q      <= '0;
         stage_q       <= '0;
         bf_in_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         s_q           <= s_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         en_q          <= en_d;
         we_q          <= we_d;
         addra_q       <= addra_d;
         addrb_q       <= addrb_d;
         tw_idx_q      <= tw_idx_d;
         stage_q       <= stage_d;
         bf_in_valid_q <= bf_in_valid_d;
      end
   end

   // Both RAM ports always move together, so one enable / write-enable flop drives each pair.
   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign ENA         = en_q;
   assign ENB         = en_q;
   assign WEA         = we_q;
   assign WEB         = we_q;
   assign ADDRA       = addra_q;
   assign ADDRB       = addrb_q;
   assign TW_IDX      = tw_idx_q;
   assign STAGE       = stage_q;
   assign BF_IN_VALID = bf_in_valid_q;

endmodule

// File: tb/tb_fft_ram_sched.sv
// Self-checking bench for fft_ram_sched (defaults CMD_WIDTH=4, BF_LAT=2).
// Reference model: a single run position counter; expected outputs derived by plain arithmetic.
module tb_fft_ram_sched;

   localparam int CW      = 4;
   localparam int BL      = 2;
   localparam int HALF    = (1 << CW) / 2;
   localparam int PER     = BL + 2;
   localparam int RUN_LEN = CW * HALF * PER;   // 128

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       ena;
      logic       enb;
      logic       wea;
      logic       web;
      logic       bfv;
      logic [3:0] addra;
      logic [3:0] addrb;
      logic [2:0] tw;
      logic [1:0] stage;
   } out_t;

   typedef struct {
      int         s;
      int         k;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] tw;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic       ABORT_I;
   logic       BUSY, DONE, ENA, ENB, WEA, WEB, BF_IN_VALID;
   logic [3:0] ADDRA, ADDRB;
   logic [2:0] TW_IDX;
   logic [1:0] STAGE;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   pos   = -1;   // -1 idle, 0..RUN_LEN-1 inside run, RUN_LEN = done cycle
   int   hits  = 0;
   int   done_cnt = 0;
   int   n;
   vec_t tbl[8];

   always #5 CLK = ~CLK;

   fft_ram_sched #(
      .CMD_WIDTH (CW),
      .BF_LAT    (BL)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
`ifdef FFT_RAM_SCHED_ABORT_EN
      .ABORT       (ABORT_I),
`endif
      .START       (START),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .ENA         (ENA),
      .ENB         (ENB),
      .WEA         (WEA),
      .WEB         (WEB),
      .ADDRA       (ADDRA),
      .ADDRB       (ADDRB),
      .TW_IDX      (TW_IDX),
      .STAGE       (STAGE),
      .BF_IN_VALID (BF_IN_VALID)
   );

   function automatic out_t model_out(int p);
      out_t o;
      int bfly, sub, s, k, span, a;
      o = '0;
      if (p == RUN_LEN) begin
         o.done = 1'b1;
      end else if (p >= 0) begin
         bfly    = p / PER;
         sub     = p % PER;
         s       = bfly / HALF;
         k       = bfly % HALF;
         span    = 1 << s;
         a       = (k / span) * (2 * span) + (k % span);
         o.busy  = 1'b1;
         o.ena   = (sub == 0) || (sub == PER - 1);
         o.enb   = o.ena;
         o.wea   = (sub == PER - 1);
         o.web   = o.wea;
         o.bfv   = (sub == 1);
         o.addra = 4'(a);
         o.addrb = 4'(a + span);
         o.tw    = 3'((k % span) * (1 << (CW - 1 - s)));
         o.stage = 2'(s);
      end
      return o;
   endfunction

   function automatic out_t dut_out();
      out_t o;
      o = {BUSY, DONE, ENA, ENB, WEA, WEB, BF_IN_VALID, ADDRA, ADDRB, TW_IDX, STAGE};
      return o;
   endfunction

   task automatic chk_out(input string nm, input out_t exp);
      out_t act;
      act = dut_out();
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t pos=%0d actual=%h required=%h", nm, $time, pos, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
      end
   endtask

   task automatic table_check();
      int bf, s, k;
      if (pos >= 0 && pos < RUN_LEN && (pos % PER) == 0) begin
         bf = pos / PER;
         s  = bf / HALF;
         k  = bf % HALF;
         for (int i = 0; i < 8; i++) begin
            if (tbl[i].s == s && tbl[i].k == k) begin
               hits++;
               chk_int("tbl_addr", int'({ADDRA, ADDRB, TW_IDX, STAGE}),
                       int'({tbl[i].a, tbl[i].b, tbl[i].tw, 2'(s)}));
            end
         end
      end
   endtask

   // One clock: drive START, advance the model at the edge, compare on the falling edge.
   task automatic tick(input logic st);
      START = st;
      @(posedge CLK);
      if (RST)                                          pos = -1;
      else if (ABORT_I && pos >= 0 && pos < RUN_LEN)    pos = -1;
      else if (pos < 0)                                 pos = START ? 0 : -1;
      else if (pos < RUN_LEN)                           pos = pos + 1;
      else                                              pos = -1;
      @(negedge CLK);
      if (DONE) done_cnt++;
      chk_out("cycle", model_out(pos));
      table_check();
   endtask

   initial begin
      RST     = 1'b1;
      START   = 1'b0;
      ABORT_I = 1'b0;
      // hand-computed butterfly vectors {s, k, ADDRA, ADDRB, TW_IDX}
      tbl[0] = '{0, 0, 4'd0, 4'd1,  3'd0};
      tbl[1] = '{0, 3, 4'd6, 4'd7,  3'd0};
      tbl[2] = '{1, 1, 4'd1, 4'd3,  3'd4};
      tbl[3] = '{1, 2, 4'd4, 4'd6,  3'd0};
      tbl[4] = '{2, 5, 4'd9, 4'd13, 3'd2};
      tbl[5] = '{2, 3, 4'd3, 4'd7,  3'd6};
      tbl[6] = '{3, 0, 4'd0, 4'd8,  3'd0};
      tbl[7] = '{3, 7, 4'd7, 4'd15, 3'd7};

      repeat (2) @(negedge CLK);
      chk_out("reset", '0);
      RST = 1'b0;

      // single START pulse: full run, latency and table vectors
      hits     = 0;
      done_cnt = 0;
      tick(1'b1);
      chk_int("first_rd", int'({ENA, ENB, WEA, WEB, ADDRA, ADDRB, TW_IDX, STAGE}),
              int'({1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 3'd0, 2'd0}));
      n = 0;
      while (!DONE && n < 300) begin
         tick(1'b0);
         n++;
      end
      chk_int("done_latency", n, RUN_LEN);
      chk_int("tbl_hits", hits, 8);
      tick(1'b0);
      chk_int("post_done", int'({BUSY, DONE}), 0);
      chk_int("done_once", done_cnt, 1);

      // START held high: exactly one run, an IDLE cycle, then the next run
      done_cnt = 0;
      repeat (262) tick(1'b1);
      chk_int("held_start_runs", done_cnt, 2);
      n = 0;
      while (pos != -1 && n < 300) begin
         tick(1'b0);
         n++;
      end

      // asynchronous reset in a BF cycle of stage 2, then restart from scratch
      tick(1'b1);
      n = 0;
      while (pos != 2 * HALF * PER + 1 && n < 300) begin
         tick(1'b0);
         n++;
      end
      chk_int("in_stage2_bf", int'({STAGE, ENA, BUSY}), int'({2'd2, 1'b0, 1'b1}));
      #2 RST = 1'b1;
      #1 chk_out("async_rst", '0);
      pos = -1;
      tick(1'b0);
      RST = 1'b0;
      tick(1'b1);
      chk_int("restart", int'({STAGE, ADDRA, ADDRB, TW_IDX, ENA}),
              int'({2'd0, 4'd0, 4'd1, 3'd0, 1'b1}));
      n = 0;
      while (pos != -1 && n < 300) begin
         tick(1'b0);
         n++;
      end

`ifdef FFT_RAM_SCHED_ABORT_EN
      // abort in WR of stage 1, k=3
      tick(1'b1);
      n = 0;
      while (pos != (HALF + 3) * PER + PER - 1 && n < 300) begin
         tick(1'b0);
         n++;
      end
      chk_int("abort_at_wr", int'({WEA, WEB, STAGE}), int'({1'b1, 1'b1, 2'd1}));
      ABORT_I  = 1'b1;
      done_cnt = 0;
      tick(1'b0);
      ABORT_I = 1'b0;
      chk_int("abort_idle", int'({BUSY, ENA, WEA, WEB}), 0);
      repeat (140) tick(1'b0);
      chk_int("abort_no_done", done_cnt, 0);
`endif

      // randomized START / reset (/ abort) traffic against the model
      for (int i = 0; i < 3000; i++) begin
         RST = ($urandom_range(0, 499) == 0);
`ifdef FFT_RAM_SCHED_ABORT_EN
         ABORT_I = ($urandom_range(0, 199) == 0);
`endif
         tick($urandom_range(0, 5) == 0);
      end
      RST     = 1'b0;
      ABORT_I = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fft_ram_sched.md
FFT_RAM_SCHED -- requirements
Module: fft_ram_sched

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 4, giving the RAM address width; N = 2^CMD_WIDTH points.
REQ-002 SHALL have parameter BF_LAT, default 2, giving the external butterfly latency in cycles (legal range >= 1).
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports are named CLK and RST.
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 START  input  1  request to run one full in-place FFT pass set.
REQ-007 BUSY  output  1  high from the cycle after START is accepted until DONE.
REQ-008 DONE  output  1  one-cycle pulse after the last butterfly write.
REQ-009 ENA, ENB  output  1 each  RAM port A/B enables.
REQ-010 WEA, WEB  output  1 each  RAM port A/B write enables.
REQ-011 ADDRA, ADDRB  output  CMD_WIDTH each  top and bottom butterfly addresses.
REQ-012 TW_IDX  output  CMD_WIDTH-1  twiddle ROM index for the current butterfly.
REQ-013 STAGE  output  $clog2(CMD_WIDTH)  current stage number s.
REQ-014 BF_IN_VALID  output  1  high when DOA/DOB hold butterfly operands (cycle after a read).

Function
REQ-015 SHALL use the FSM states IDLE, RD, BF, WR, DONE.
REQ-016 IDLE SHALL go to RD on START=1; otherwise it SHALL stay in IDLE. START while not in IDLE SHALL be ignored.
REQ-017 In RD (1 cycle), the block SHALL assert ENA=ENB=1 and WEA=WEB=0 with the pair addresses; BF_IN_VALID SHALL be high in the following cycle.
REQ-018 BF SHALL last exactly BF_LAT cycles with ENA=ENB=0, driven by a down-counter.
REQ-019 In WR (1 cycle), the block SHALL assert ENA=ENB=WEA=WEB=1 with the same addresses as the preceding RD.
REQ-020 After WR, the block SHALL advance the pair index k (0..N/2-1). On wrap, it SHALL advance stage s (0..CMD_WIDTH-1). After the last pair of the last stage it SHALL go to DONE; otherwise it SHALL go to RD.
REQ-021 DONE SHALL last 1 cycle with DONE=1 and BUSY=0, then go to IDLE.
REQ-022 Addressing (DIT, bit-reversed input already in RAM), with span = 2^s:
  - ADDRA = ((k>>s)<<(s+1)) | (k & (span-1))
  - ADDRB = ADDRA + span
  - TW_IDX = (k & (span-1)) << (CMD_WIDTH-1-s)
REQ-023 Total run length from START acceptance to DONE SHALL be CMD_WIDTH * N/2 * (BF_LAT+2) cycles (128 for the defaults).
REQ-024 All outputs SHALL be registered. Addresses, TW_IDX and STAGE SHALL hold their values through RD, BF and WR of a butterfly.

Reset
REQ-025 RST=1 SHALL force, asynchronously, state=IDLE, k=0, s=0, counter=0, and all outputs 0, including mid-run.
REQ-026 After RST deasserts, the block SHALL wait for a new START; no partial run resumes.

Configuration
REQ-027 With FFT_RAM_SCHED_ABORT_EN defined, input ABORT (1 bit) SHALL exist. ABORT=1 in RD, BF or WR SHALL force IDLE on the next edge, with enables 0, k=s=0, and no DONE pulse. ABORT in IDLE or DONE SHALL have no effect.
REQ-028 Without FFT_RAM_SCHED_ABORT_EN, the ABORT port and its logic SHALL be absent.

Structure
REQ-029 A shared package fft_pkg SHALL hold the FSM state enum and the default CMD_WIDTH/BF_LAT constants.
REQ-030 The address/twiddle computation SHALL be one sub-module, fft_addr_gen (combinational from s, k), instantiated once.

Verification
REQ-031 Defaults, START pulse at t0: first RD SHALL show ADDRA=0, ADDRB=1, TW_IDX=0, STAGE=0, ENA=ENB=1, WE=0.
REQ-032 Stage 1, k=1 SHALL show ADDRA=1, ADDRB=3, TW_IDX=4. Stage 2, k=5 SHALL show ADDRA=9, ADDRB=13, TW_IDX=2.
REQ-033 Last butterfly (stage 3, k=7) SHALL show ADDRA=7, ADDRB=15, TW_IDX=7. DONE SHALL pulse once, 128 cycles after acceptance, followed by BUSY=0.
REQ-034 START held high through the whole run SHALL give exactly one run, then a second run starting from IDLE.
REQ-035 RST asserted during a BF state of stage 2 SHALL zero all outputs immediately. A new START SHALL restart at stage 0, k=0.
REQ-036 With FFT_RAM_SCHED_ABORT_EN, ABORT in WR of stage 1, k=3 SHALL give WEA=WEB=0 and IDLE next cycle, with no DONE pulse.
